// File: rtl/hdpldadapt_sr_ser.sv
// rtl/hdpldadapt_sr_ser.sv - serializer for the shift-register chain: parallel frame in, LSB-first serial out.
// Optional debug bus enabled by HDPLDADAPT_SR_SER_TESTBUS_EN.
module hdpldadapt_sr_ser #(
   parameter logic [6:0] NUM_OF_PCS_CHAIN            = 7'd16,
   parameter logic [6:0] NUM_OF_HIP_CHAIN            = 7'd16,
   parameter logic [6:0] NUM_OF_RESERVED_CHAIN_SSRIN = 7'd5
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   sr_loadout,
   input  logic                                   r_sr_hip_en,
   input  logic                                   r_sr_parity_en,
   input  logic                                   r_sr_reserbits_in_en,
   input  logic                                   sr_err_clr,
   input  logic [NUM_OF_PCS_CHAIN-1:0]            pcs_data_in,
   input  logic [NUM_OF_HIP_CHAIN-1:0]            hip_data_in,
   input  logic [NUM_OF_RESERVED_CHAIN_SSRIN-1:0] reserved_in,
   output logic                                   sr_dataout,
   output logic                                   sr_frame_done,
   output logic                                   sr_frame_err,
   output logic [11:0]                            sr_ser_testbus
);

   // Widest frame is PCS+HIP+RESERVED; the parity slot only exists when HIP is off.
   localparam int W = int'(NUM_OF_PCS_CHAIN) + int'(NUM_OF_HIP_CHAIN) + int'(NUM_OF_RESERVED_CHAIN_SSRIN);

   logic [W-1:0] r_shift;
   logic [6:0]   r_bit_cnt;
   logic [6:0]   r_frame_len;
   logic         r_frame_active;
   logic         r_frame_done;
   logic         r_frame_err;

   logic [W-1:0] w_frame;
   logic [6:0]   w_mid_len;
   logic [6:0]   w_len;
   logic         w_trunc;
   logic         w_last;

   always_comb begin
      w_mid_len = 7'd0;
      if (r_sr_hip_en)
         w_mid_len = NUM_OF_HIP_CHAIN;
      else if (r_sr_parity_en)
         w_mid_len = 7'd1;

      w_len = NUM_OF_PCS_CHAIN + w_mid_len;
      if (r_sr_reserbits_in_en)
         w_len = w_len + NUM_OF_RESERVED_CHAIN_SSRIN;

      w_frame = W'(pcs_data_in);
      if (r_sr_hip_en)
         w_frame = w_frame | (W'(hip_data_in) << NUM_OF_PCS_CHAIN);
      else if (r_sr_parity_en)
         w_frame[NUM_OF_PCS_CHAIN] = ^pcs_data_in;
      if (r_sr_reserbits_in_en)
         w_frame = w_frame | (W'(reserved_in) << (NUM_OF_PCS_CHAIN + w_mid_len));
   end

   // A load with bit_cnt==0 is the controller's held-load idle, not a truncation.
   assign w_trunc = r_frame_active && (r_bit_cnt != 7'd0);
   assign w_last  = r_frame_active && (r_bit_cnt == r_frame_len - 7'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift        <= '0;
         r_bit_cnt      <= 7'd0;
         r_frame_len    <= NUM_OF_PCS_CHAIN;
         r_frame_active <= 1'b0;
         r_frame_done   <= 1'b0;
         r_frame_err    <= 1'b0;
      end else if (sr_loadout) begin
         r_shift        <= w_frame;
         r_bit_cnt      <= 7'd0;
         r_frame_len    <= w_len;
         r_frame_active <= 1'b1;
         r_frame_done   <= 1'b0;
         if (w_trunc)
            r_frame_err <= 1'b1;
         else if (sr_err_clr)
            r_frame_err <= 1'b0;
      end else begin
         r_shift      <= r_shift >> 1;
         r_bit_cnt    <= (r_bit_cnt == 7'h7F) ? 7'h7F : r_bit_cnt + 7'd1;
         r_frame_done <= w_last;
         if (w_last)
            r_frame_active <= 1'b0;
         if (sr_err_clr)
            r_frame_err <= 1'b0;
      end
   end

   assign sr_dataout    = r_shift[0];
   assign sr_frame_done = r_frame_done;
   assign sr_frame_err  = r_frame_err;

`ifdef HDPLDADAPT_SR_SER_TESTBUS_EN
   assign sr_ser_testbus = {r_frame_active, r_frame_err, r_frame_done, r_shift[0], 1'b0, r_bit_cnt};
`else
   assign sr_ser_testbus = 12'h000;
`endif

endmodule

// File: tb/tb_hdpldadapt_sr_ser.sv
// tb/tb_hdpldadapt_sr_ser.sv - directed scoreboard bench for hdpldadapt_sr_ser.
module tb_hdpldadapt_sr_ser;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sr_loadout = 1'b0;
   logic        hip_en = 1'b0;
   logic        par_en = 1'b0;
   logic        res_en = 1'b0;
   logic        err_clr = 1'b0;
   logic [15:0] pcs = 16'h0;
   logic [15:0] hip = 16'h0;
   logic [4:0]  res = 5'h0;
   logic        sr_dataout;
   logic        sr_frame_done;
   logic        sr_frame_err;
   logic [11:0] sr_ser_testbus;

   int checks = 0;
   int failures = 0;
   logic exp_q[$];

   hdpldadapt_sr_ser dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .sr_loadout           (sr_loadout),
      .r_sr_hip_en          (hip_en),
      .r_sr_parity_en       (par_en),
      .r_sr_reserbits_in_en (res_en),
      .sr_err_clr           (err_clr),
      .pcs_data_in          (pcs),
      .hip_data_in          (hip),
      .reserved_in          (res),
      .sr_dataout           (sr_dataout),
      .sr_frame_done        (sr_frame_done),
      .sr_frame_err         (sr_frame_err),
      .sr_ser_testbus       (sr_ser_testbus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: the whole expected bit stream is pushed when the frame is loaded.
   task automatic model_load();
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(pcs[i]);
      if (hip_en) begin
         for (int i = 0; i < 16; i++) exp_q.push_back(hip[i]);
      end else if (par_en) begin
         exp_q.push_back(^pcs);
      end
      if (res_en) begin
         for (int i = 0; i < 5; i++) exp_q.push_back(res[i]);
      end
   endtask

   task automatic pop_bit(output logic b);
      if (exp_q.size() == 0) b = 1'b0;
      else b = exp_q.pop_front();
   endtask

   task automatic do_load(input string tag, input logic exp_err);
      logic b;
      model_load();
      sr_loadout = 1'b1;
      @(posedge clk); #1;
      pop_bit(b);
      chk({tag, "_bit0"}, sr_dataout, b);
      chk({tag, "_done_on_load"}, sr_frame_done, 1'b0);
      chk({tag, "_err_on_load"}, sr_frame_err, exp_err);
   endtask

   task automatic do_shift(input string tag, input logic exp_done);
      logic b;
      sr_loadout = 1'b0;
      @(posedge clk); #1;
      pop_bit(b);
      chk({tag, "_bit"}, sr_dataout, b);
      chk({tag, "_done"}, sr_frame_done, exp_done);
   endtask

   // Format and data inputs are scrambled after capture; the frame in flight must not change.
   task automatic run_frame(input string tag, input int n, input logic exp_err);
      do_load(tag, exp_err);
      for (int k = 1; k <= n + 2; k++) begin
         if (k == 1) begin
            pcs = 16'($urandom); hip = 16'($urandom); res = 5'($urandom);
            hip_en = 1'($urandom); par_en = 1'($urandom); res_en = 1'($urandom);
         end
         do_shift(tag, k == n);
      end
      chk({tag, "_err_end"}, sr_frame_err, exp_err);
   endtask

   initial begin
      #12;
      chk("rst_dataout", sr_dataout, 1'b0);
      chk("rst_done", sr_frame_done, 1'b0);
      chk("rst_err", sr_frame_err, 1'b0);
`ifndef HDPLDADAPT_SR_SER_TESTBUS_EN
      chk("rst_testbus", sr_ser_testbus, 12'h000);
`endif
      @(negedge clk); rst_n = 1'b1;

      hip_en = 0; par_en = 0; res_en = 0; pcs = 16'hA5C3;
      run_frame("plain16", 16, 1'b0);

      hip_en = 0; par_en = 1; res_en = 0; pcs = 16'h0007;
      run_frame("par_odd", 17, 1'b0);
      hip_en = 0; par_en = 1; res_en = 0; pcs = 16'h0003;
      run_frame("par_even", 17, 1'b0);

      hip_en = 1; par_en = 1; res_en = 1; pcs = 16'h1234; hip = 16'hFFFF; res = 5'b10101;
      run_frame("full37", 37, 1'b0);

      hip_en = 0; par_en = 0; res_en = 1; pcs = 16'h8001; res = 5'b01110;
      run_frame("res21", 21, 1'b0);

      hip_en = 0; par_en = 0; res_en = 0; pcs = 16'h1234;
      do_load("trunc_a", 1'b0);
      for (int k = 1; k <= 5; k++) do_shift("trunc_a", 1'b0);
      pcs = 16'hBEEF;
      do_load("trunc_b", 1'b1);
      for (int k = 1; k <= 16; k++) do_shift("trunc_b", k == 16);
      chk("trunc_err_sticky", sr_frame_err, 1'b1);
      err_clr = 1'b1;
      do_shift("trunc_clr", 1'b0);
      err_clr = 1'b0;
      chk("trunc_err_cleared", sr_frame_err, 1'b0);

      pcs = 16'h5A5B;
      for (int k = 0; k < 10; k++) do_load("held", 1'b0);
      for (int k = 1; k <= 17; k++) do_shift("held_tail", k == 16);

      hip_en = 1; par_en = 0; res_en = 0; pcs = 16'hC3A5; hip = 16'h0F0F;
      do_load("rstmid", 1'b0);
      for (int k = 1; k <= 8; k++) do_shift("rstmid", 1'b0);
      #3 rst_n = 1'b0;
      #1;
      chk("rstmid_dataout", sr_dataout, 1'b0);
      chk("rstmid_done", sr_frame_done, 1'b0);
      chk("rstmid_err", sr_frame_err, 1'b0);
`ifndef HDPLDADAPT_SR_SER_TESTBUS_EN
      chk("rstmid_testbus", sr_ser_testbus, 12'h000);
`endif
      @(negedge clk); rst_n = 1'b1;
      hip_en = 1; par_en = 0; res_en = 0; pcs = 16'h00FF; hip = 16'hAAAA;
      run_frame("post_rst", 32, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
